// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - shared kernel one-hot codes and scheduler state encoding
package acc_pkg;

    localparam logic [2:0] KER_FIR  = 3'b001;
    localparam logic [2:0] KER_MAT  = 3'b010;
    localparam logic [2:0] KER_SORT = 3'b100;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RUN    = 2'd2,
        RETIRE = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter3.sv
// rtl/rr_arbiter3.sv - 3-way round-robin pick; the bit after last_i has top priority
module rr_arbiter3
    import acc_pkg::*;
(
    input  logic [2:0] req_i,
    input  logic [2:0] last_i,
    output logic [2:0] grant_o
);

    always_comb begin
        grant_o = 3'b000;
        unique case (last_i)
            KER_FIR: begin
                if      (req_i[1]) grant_o = KER_MAT;
                else if (req_i[2]) grant_o = KER_SORT;
                else if (req_i[0]) grant_o = KER_FIR;
            end
            KER_MAT: begin
                if      (req_i[2]) grant_o = KER_SORT;
                else if (req_i[0]) grant_o = KER_FIR;
                else if (req_i[1]) grant_o = KER_MAT;
            end
            default: begin
                if      (req_i[0]) grant_o = KER_FIR;
                else if (req_i[1]) grant_o = KER_MAT;
                else if (req_i[2]) grant_o = KER_SORT;
            end
        endcase
    end

endmodule

// File: rtl/acc_sched.sv
// rtl/acc_sched.sv - accelerator job scheduler; ACC_SCHED_TIMEOUT_EN adds a watchdog
module acc_sched
    import acc_pkg::*;
#(
    parameter int TIMEOUT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2:0]           req_valid,
    output logic [2:0]           req_ready,
    output logic [2:0]           cmp_valid,
    output logic                 cmp_err,
    output logic [2:0]           acc_ap_start,
    input  logic                 acc_ap_idle,
    input  logic [2:0]           acc_ap_done,
    input  logic                 mon_tvalid,
    input  logic                 mon_tready,
    input  logic                 mon_tlast,
    input  logic [TIMEOUT_W-1:0] timeout_cycles,
    output logic                 busy,
    output logic [2:0]           cur_job
);

    state_t     state_q, state_d;
    logic [2:0] cur_job_q, cur_job_d;
    logic [2:0] last_q, last_d;
    logic       done_seen_q, done_seen_d;
    logic       last_seen_q, last_seen_d;
    logic [2:0] req_ready_q, req_ready_d;
    logic [2:0] cmp_valid_q, cmp_valid_d;
    logic       cmp_err_q, cmp_err_d;
    logic [2:0] start_q, start_d;
    logic       busy_q, busy_d;
    logic [2:0] grant;
    logic       wd_hit;

    rr_arbiter3 u_arb (
        .req_i   (req_valid),
        .last_i  (last_q),
        .grant_o (grant)
    );

`ifdef ACC_SCHED_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] wd_q, wd_d;

    // wd_d is the 1-based count of ISSUE+RUN cycles including the current one
    always_comb begin
        wd_d   = '0;
        wd_hit = 1'b0;
        if (state_q == ISSUE || state_q == RUN) begin
            wd_d   = (wd_q == '1) ? wd_q : wd_q + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
            wd_hit = (timeout_cycles != '0) && (wd_d >= timeout_cycles);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wd_q <= '0;
        else        wd_q <= wd_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^timeout_cycles;
    assign wd_hit         = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cur_job_d   = cur_job_q;
        last_d      = last_q;
        done_seen_d = done_seen_q;
        last_seen_d = last_seen_q;
        req_ready_d = 3'b000;
        cmp_valid_d = 3'b000;
        cmp_err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid != 3'b000) begin
                    state_d     = ISSUE;
                    cur_job_d   = grant;
                    req_ready_d = grant;
                end
            end
            ISSUE: begin
                if (wd_hit) begin
                    state_d     = RETIRE;
                    cmp_valid_d = cur_job_q;
                    cmp_err_d   = 1'b1;
                end else if (!acc_ap_idle) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if ((acc_ap_done & cur_job_q) != 3'b000)   done_seen_d = 1'b1;
                if (mon_tvalid && mon_tready && mon_tlast) last_seen_d = 1'b1;
                // a genuine completion in the same cycle as the timeout wins
                if (done_seen_d && last_seen_d) begin
                    state_d     = RETIRE;
                    cmp_valid_d = cur_job_q;
                end else if (wd_hit) begin
                    state_d     = RETIRE;
                    cmp_valid_d = cur_job_q;
                    cmp_err_d   = 1'b1;
                end
            end
            RETIRE: begin
                state_d     = IDLE;
                last_d      = cur_job_q;
                cur_job_d   = 3'b000;
                done_seen_d = 1'b0;
                last_seen_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        start_d = (state_d == ISSUE) ? cur_job_d : 3'b000;
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_job_q   <= 3'b000;
            last_q      <= KER_SORT;
            done_seen_q <= 1'b0;
            last_seen_q <= 1'b0;
            req_ready_q <= 3'b000;
            cmp_valid_q <= 3'b000;
            cmp_err_q   <= 1'b0;
            start_q     <= 3'b000;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_job_q   <= cur_job_d;
            last_q      <= last_d;
            done_seen_q <= done_seen_d;
            last_seen_q <= last_seen_d;
            req_ready_q <= req_ready_d;
            cmp_valid_q <= cmp_valid_d;
            cmp_err_q   <= cmp_err_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign cmp_valid    = cmp_valid_q;
    assign cmp_err      = cmp_err_q;
    assign acc_ap_start = start_q;
    assign busy         = busy_q;
    assign cur_job      = cur_job_q;

endmodule

// File: tb/tb_acc_sched.sv
// tb/tb_acc_sched.sv - scoreboard bench for acc_sched (timeout checks follow ACC_SCHED_TIMEOUT_EN)
module tb_acc_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [2:0]  cmp_valid;
    logic        cmp_err;
    logic [2:0]  acc_ap_start;
    logic        acc_ap_idle;
    logic [2:0]  acc_ap_done;
    logic        mon_tvalid, mon_tready, mon_tlast;
    logic [15:0] timeout_cycles;
    logic        busy;
    logic [2:0]  cur_job;

    int total = 0;
    int bad   = 0;
    int rr_last_idx = 2;
    logic [2:0] grant_q[$];
    logic [3:0] cmp_q[$];

    acc_sched #(.TIMEOUT_W(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .cmp_valid      (cmp_valid),
        .cmp_err        (cmp_err),
        .acc_ap_start   (acc_ap_start),
        .acc_ap_idle    (acc_ap_idle),
        .acc_ap_done    (acc_ap_done),
        .mon_tvalid     (mon_tvalid),
        .mon_tready     (mon_tready),
        .mon_tlast      (mon_tlast),
        .timeout_cycles (timeout_cycles),
        .busy           (busy),
        .cur_job        (cur_job)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference arbitration: first requesting kernel after the last granted one
    function automatic int model_pick(input logic [2:0] mask);
        logic [2:0] m;
        m = mask;
        for (int k = 1; k <= 3; k++) begin
            if (m[(rr_last_idx + k) % 3]) return (rr_last_idx + k) % 3;
        end
        return -1;
    endfunction

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (req_ready != 3'b000) begin
                if (grant_q.size() == 0) check("unexpected_grant", int'(req_ready), 0);
                else check("grant", int'(req_ready), int'(grant_q.pop_front()));
            end
            if (cmp_valid != 3'b000) begin
                if (cmp_q.size() == 0) check("unexpected_cmp", int'({cmp_valid, cmp_err}), 0);
                else check("cmp_job_err", int'({cmp_valid, cmp_err}), int'(cmp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_done(input logic [2:0] v);
        acc_ap_done = v;
        tick();
        acc_ap_done = 3'b000;
    endtask

    task automatic beat(input logic tl);
        mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tlast = tl;
        tick();
        mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tlast = 1'b0;
    endtask

    task automatic issue(input logic [2:0] mask, output logic [2:0] win);
        int idx, n;
        idx = model_pick(mask);
        win = 3'b001 << idx;
        rr_last_idx = idx;
        grant_q.push_back(win);
        req_valid = mask;
        n = 0;
        @(negedge clk);
        while (req_ready == 3'b000 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("grant_seen", int'(req_ready != 3'b000), 1);
        check("cur_job", int'(cur_job), int'(win));
        check("start_in_issue", int'(acc_ap_start), int'(win));
        check("busy_issue", int'(busy), 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        check("job_retired", int'(busy), 0);
    endtask

    task automatic run_job(input logic [2:0] mask, input int mode, input bit spur);
        logic [2:0] win;
        issue(mask, win);
        cmp_q.push_back({win, 1'b0});
        tick();
        req_valid = 3'b000;
        repeat ($urandom_range(0, 3)) tick();
        check("start_held", int'(acc_ap_start), int'(win));
        acc_ap_idle = 1'b0;
        tick();
        check("start_dropped", int'(acc_ap_start), 0);
        if (spur) begin
            acc_ap_done = ~win;
            beat(1'b0);
            acc_ap_done = 3'b000;
            mon_tvalid = 1'b1; mon_tlast = 1'b1;
            tick();
            mon_tvalid = 1'b0; mon_tlast = 1'b0;
            tick();
            check("spurious_no_retire", int'({busy, cur_job}), int'({1'b1, win}));
        end
        case (mode)
            0: begin
                pulse_done(win);
                tick();
                check("done_alone_holds", int'(busy), 1);
                beat(1'b1);
            end
            1: begin
                beat(1'b1);
                tick();
                check("last_alone_holds", int'(busy), 1);
                pulse_done(win);
            end
            default: begin
                acc_ap_done = win;
                beat(1'b1);
                acc_ap_done = 3'b000;
            end
        endcase
        acc_ap_idle = 1'b1;
        wait_idle();
    endtask

    task automatic timeout_job(input logic [15:0] tmo);
        logic [2:0] win;
        bit expect_to;
        int c;
`ifdef ACC_SCHED_TIMEOUT_EN
        expect_to = (tmo != 16'd0);
`else
        expect_to = 1'b0;
`endif
        timeout_cycles = tmo;
        issue(3'($urandom_range(1, 7)), win);
        if (expect_to) cmp_q.push_back({win, 1'b1});
        c = 0;
        while (c < 120 && cmp_valid == 3'b000) begin
            @(posedge clk);
            #1;
            if (c == 0) req_valid = 3'b000;
            if (c == 3) acc_ap_idle = 1'b0;
            @(negedge clk);
            c++;
        end
        if (expect_to) begin
            check("timeout_cycle", c, int'(tmo));
        end else begin
            check("no_timeout_busy", int'(busy), 1);
            cmp_q.push_back({win, 1'b0});
            tick();
            acc_ap_done = win;
            beat(1'b1);
            acc_ap_done = 3'b000;
        end
        acc_ap_idle = 1'b1;
        wait_idle();
        timeout_cycles = 16'd0;
    endtask

    initial begin
        #600000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic [2:0] win;
        rst_n = 1'b0;
        req_valid = 3'b000; acc_ap_idle = 1'b1; acc_ap_done = 3'b000;
        mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tlast = 1'b0;
        timeout_cycles = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              int'({req_ready, cmp_valid, cmp_err, acc_ap_start, busy, cur_job}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) run_job(3'b111, i % 3, 1'b0);
        run_job(3'b001, 0, 1'b0);
        run_job(3'($urandom_range(1, 7)), 1, 1'b0);
        run_job(3'($urandom_range(1, 7)), 2, 1'b0);
        run_job(3'b010, 2, 1'b1);

        timeout_job(16'd20);
        timeout_job(16'd0);

        // abort a job mid-RUN with reset
        issue(3'b100, win);
        tick();
        req_valid = 3'b110;
        acc_ap_idle = 1'b0;
        tick();
        tick();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_mid_run",
              int'({req_ready, cmp_valid, cmp_err, acc_ap_start, busy, cur_job}), 0);
        cmp_q.delete();
        rr_last_idx = 2;
        acc_ap_idle = 1'b1;
        req_valid = 3'b000;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        run_job(3'b110, 2, 1'b0);

        for (int i = 0; i < 20; i++)
            run_job(3'($urandom_range(1, 7)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));

        tick();
        check("grant_q_empty", grant_q.size(), 0);
        check("cmp_q_empty", cmp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/acc_sched.md
ACC_SCHED -- requirements
Module: acc_sched

Interface
REQ-001 Parameter: TIMEOUT_W, 16, width of the watchdog counter and the timeout_cycles port.
REQ-002 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-004 Port: req_valid  in  3  per-kernel job request, level-held until granted; bit0 fir, bit1 matmul, bit2 sorting.
REQ-005 Port: req_ready  out  3  one-cycle grant pulse, one-hot, to the requester whose job is issued.
REQ-006 Port: cmp_valid  out  3  one-cycle completion pulse, one-hot, to the owner of the retired job.
REQ-007 Port: cmp_err  out  1  qualifies cmp_valid; high means the job was retired by timeout.
REQ-008 Port: acc_ap_start  out  3  one-hot kernel start to the accelerator.
REQ-009 Port: acc_ap_idle  in  1  accelerator idle flag.
REQ-010 Port: acc_ap_done  in  3  accelerator per-kernel done.
REQ-011 Port: mon_tvalid, mon_tready, mon_tlast  in  1 each  passive taps on the accelerator output stream.
REQ-012 Port: timeout_cycles  in  TIMEOUT_W  watchdog limit; 0 disables the watchdog.
REQ-013 Port: busy  out  1  high in every state except IDLE.
REQ-014 Port: cur_job  out  3  one-hot kernel currently owned; 0 in IDLE.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, RUN and RETIRE.
REQ-016 Transitions: IDLE->ISSUE when req_valid!=0; ISSUE->RUN on the first cycle acc_ap_idle==0; RUN->RETIRE when done_seen and last_seen are both set; RETIRE->IDLE unconditionally after 1 cycle.
REQ-017 Arbitration SHALL be round-robin over the 3 bits; highest priority goes to the bit after the last granted bit; after reset, bit0 (fir) has highest priority.
REQ-018 The winner SHALL be latched into cur_job on the IDLE->ISSUE edge, with req_ready pulsed for that same clock.
REQ-019 acc_ap_start SHALL equal cur_job throughout ISSUE and 0 otherwise (registered output, first asserted 1 cycle after req_valid is sampled in IDLE).
REQ-020 done_seen SHALL set in RUN when (acc_ap_done & cur_job)!=0; non-matching done bits are ignored.
REQ-021 last_seen SHALL set in RUN on mon_tvalid&mon_tready&mon_tlast; done and last may arrive in either order or in the same cycle.
REQ-022 RETIRE SHALL pulse cmp_valid=cur_job for 1 cycle, clear done_seen/last_seen, and update the round-robin pointer.
REQ-023 New requests arriving outside IDLE SHALL wait; there is no queueing beyond the req_valid levels.
REQ-024 All outputs SHALL be registered.

Reset
REQ-025 When rst_n is low, state=IDLE, every output=0, done_seen/last_seen=0, rr pointer=fir-first, watchdog=0, with immediate effect even mid-job; no cmp_valid is produced for the aborted job.

Configuration
REQ-026 With ACC_SCHED_TIMEOUT_EN defined, a watchdog SHALL count cycles in ISSUE and RUN, and on reaching timeout_cycles (nonzero) SHALL go to RETIRE with cmp_err=1; the counter saturates and clears in IDLE.
REQ-027 Without ACC_SCHED_TIMEOUT_EN, there is no counter, cmp_err is tied 0, and timeout_cycles is ignored.

Structure
REQ-028 Shared package acc_pkg SHALL hold the kernel one-hot constants KER_FIR=001, KER_MAT=010, KER_SORT=100 and the FSM state encoding.
REQ-029 Round-robin selection SHALL live in sub-module rr_arbiter3 (req, last-grant pointer -> one-hot grant).

Verification
REQ-030 Single fir job: req_valid=001 -> req_ready=001 for 1 cycle, acc_ap_start=001 until idle drops; ap_done=001, then tlast beat -> cmp_valid=001, cmp_err=0.
REQ-031 Fairness: req_valid=111 held, each job completed -> grant order 001, 010, 100, 001.
REQ-032 Ordering: tlast beat before ap_done, and in a second job both in the same cycle -> exactly one cmp_valid per job in each case.
REQ-033 Spurious done: matmul running, ap_done=100 -> no retire; then ap_done=010 plus tlast -> cmp_valid=010.
REQ-034 Timeout (macro on): timeout_cycles=20, no ap_done -> cmp_valid=cur_job with cmp_err=1 at cycle 20 of ISSUE+RUN; timeout_cycles=0 -> never times out.
REQ-035 Reset mid-RUN: rst_n low -> all outputs 0 immediately; after release, req_valid=110 -> grant 010.
